ultrasonic_multi_sensor: RTL and testbench
==========================================

# ultrasonic_multi_sensor

Multi-channel HC-SR04 controller: fires N sensors one at a time in a round-robin schedule to avoid acoustic crosstalk, and measures each echo directly in whole centimetres. It also flags missing or over-range echoes. It sits between the board echo/trig pins and display or robot-control logic, and provides per-channel distance registers plus a per-measurement strobe.

## Interface
- `clk_frequency`, 50000000, clock frequency in Hz.
- `n_channels`, 4, number of sensors (≥1).
- `distance_width`, 9, distance register width in cm (must hold `max_range_in_centimeters`).
- `max_range_in_centimeters`, 400, saturation and timeout range.
- `slot_in_milliseconds`, 60, time slot per channel.
- `trig_time_in_microseconds`, 10, trig pulse width.
- `near_threshold_in_centimeters`, 30, near-flag threshold.
- Derived values:
  - `slot_time = slot_in_milliseconds*(clk_frequency/1000)`
  - `trig_time = trig_time_in_microseconds*(clk_frequency/1000000)`
  - `cycles_per_cm = clk_frequency*2/343/100`
  - `timeout_time = max_range_in_centimeters*cycles_per_cm`
- Elaboration error unless `slot_time > trig_time + 2*timeout_time`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `trig`  out  n_channels  one-hot trigger, one bit per sensor.
- `echo`  in  n_channels  raw asynchronous echo pins.
- `distance`  out  n_channels*distance_width  flat bus; channel k at `[k*distance_width +: distance_width]`.
- `valid`  out  n_channels  channel has completed at least one measurement.
- `timeout`  out  n_channels  last measurement of the channel timed out.
- `near`  out  n_channels  channel closer than threshold (see Configuration).
- `strobe`  out  1  one-cycle pulse when a measurement result is written.
- `strobe_channel`  out  $clog2(n_channels) (min 1)  channel index written on `strobe`.

## Operation
- Echo inputs pass through a 2-flop synchronizer per bit. Edge detection uses a third registered copy of the selected channel only; echo on unselected channels is ignored.
- A slot counter runs 0..slot_time-1. At slot_time-1 it wraps, `ch` advances (n_channels-1 wraps to 0), and the FSM enters TRIG.
- FSM states:
  - **TRIG**: `trig[ch]`=1 for slot counts 0..trig_time-1, then go to WAIT.
  - **WAIT**: wait for the synchronized rising edge. On the edge, clear the prescaler and cm counter and go to MEAS. If `timeout_time` cycles elapse without an edge, write a timeout result and go to GAP.
  - **MEAS**: the prescaler counts 0..cycles_per_cm-1; the cm counter increments on each prescaler wrap.
    - Falling edge: write distance = cm counter, clear timeout, and go to GAP.
    - cm counter reaching `max_range_in_centimeters` while echo is still high: write a timeout result and go to GAP.
  - **GAP**: idle until slot end. All echo edges are ignored.
- A timeout result writes `distance[ch]` = `max_range_in_centimeters` and sets `timeout[ch]`=1.
- Every result write sets `valid[ch]`, pulses `strobe`, and sets `strobe_channel`=ch.
- Echo already high at TRIG exit is not a rising edge. The block stays in WAIT until echo goes low and then high again.
- A falling edge and cm saturation in the same cycle: the falling edge wins (distance=max, timeout=0).
- cm counter width is `distance_width`. Arithmetic never wraps; the counter saturates at max.

## Timing
- Reset values: `trig`=0, `distance`=0, `valid`=0, `timeout`=0, `near`=0, `strobe`=0, `strobe_channel`=0. Internally ch=0, slot counter=0, state TRIG.
- The first `trig[0]` rises on the first clk edge after reset deassertion.
- Trig pulse is exactly trig_time cycles wide. One full round takes n_channels*slot_time cycles.
- Echo-to-detection latency is 3 cycles (2 synchronizer flops plus the edge register).
- `distance`, `timeout`, `valid` and `strobe` update on the clock edge after a detected falling edge, timeout, or saturation.
- `near` updates one cycle after `distance`.
- Reset mid-slot aborts immediately to the reset values.

## Configuration
- `ULTRASONIC_NEAR_DETECT_EN` defined: `near[k] = valid[k] & ~timeout[k] & (distance_k < near_threshold_in_centimeters)`, registered.
- Not defined: `near` is tied to 0 and no comparator logic is built. The port is always present.

## Test plan
All scenarios use clk_frequency=1000000, n_channels=4, giving cycles_per_cm=58, trig_time=10, slot_time=60000 and timeout_time=23200.

- Reset release → `trig` = 4'b0001 for exactly 10 cycles; `trig[1]` rises 60000 cycles after `trig[0]`; the `trig` bits never overlap.
- `echo[0]` high for 580 cycles after trig → `distance` ch0 = 10, `timeout[0]`=0, `valid[0]`=1; one `strobe` with `strobe_channel`=0.
- No echo on ch2 → after 23200 cycles in WAIT, `distance` ch2 = 400, `timeout[2]`=1, one `strobe`.
- `echo[1]` held high for 30000 cycles → saturation: `distance` ch1 = 400, `timeout[1]`=1. A later 1160-cycle echo → 20 and `timeout[1]`=0.
- `echo[3]` pulses during ch0's slot → no effect on any register. Reset asserted mid-MEAS → all outputs return to 0 and `trig[0]` restarts.
- With `ULTRASONIC_NEAR_DETECT_EN`: ch0 echo 1682 cycles (29 cm) → `near[0]`=1; 1740 cycles (30 cm) → `near[0]`=0. Without the macro, `near` stays 0.

Source files
------------

// File: rtl/ultrasonic_multi_sensor.sv
// rtl/ultrasonic_multi_sensor.sv - round-robin multi-channel HC-SR04 ranging controller; optional near flags via ULTRASONIC_NEAR_DETECT_EN
module ultrasonic_multi_sensor #(
    parameter int clk_frequency                 = 50000000,
    parameter int n_channels                    = 4,
    parameter int distance_width                = 9,
    parameter int max_range_in_centimeters      = 400,
    parameter int slot_in_milliseconds          = 60,
    parameter int trig_time_in_microseconds     = 10,
    parameter int near_threshold_in_centimeters = 30,
    localparam int ch_width = (n_channels > 1) ? $clog2(n_channels) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic [n_channels-1:0]                trig,
    input  logic [n_channels-1:0]                echo,
    output logic [n_channels*distance_width-1:0] distance,
    output logic [n_channels-1:0]                valid,
    output logic [n_channels-1:0]                timeout,
    output logic [n_channels-1:0]                near,
    output logic                                 strobe,
    output logic [ch_width-1:0]                  strobe_channel
);

    localparam int slot_time     = slot_in_milliseconds * (clk_frequency / 1000);
    localparam int trig_time     = trig_time_in_microseconds * (clk_frequency / 1000000);
    localparam int cycles_per_cm = clk_frequency * 2 / 343 / 100;
    localparam int timeout_time  = max_range_in_centimeters * cycles_per_cm;
    localparam int cnt_w         = $clog2(slot_time);
    localparam int psc_w         = (cycles_per_cm > 1) ? $clog2(cycles_per_cm) : 1;

    localparam logic [cnt_w-1:0]          slot_last = cnt_w'(slot_time - 1);
    localparam logic [cnt_w-1:0]          trig_last = cnt_w'(trig_time - 1);
    localparam logic [cnt_w-1:0]          trig_end  = cnt_w'(trig_time);
    localparam logic [cnt_w-1:0]          wait_last = cnt_w'(trig_time + timeout_time - 1);
    localparam logic [psc_w-1:0]          psc_last  = psc_w'(cycles_per_cm - 1);
    localparam logic [distance_width-1:0] max_cm    = distance_width'(max_range_in_centimeters);
    localparam logic [ch_width-1:0]       ch_last   = ch_width'(n_channels - 1);

    if (slot_time <= trig_time + 2 * timeout_time) begin : g_bad_slot
        $error("slot_time must exceed trig_time + 2*timeout_time");
    end
    if (max_range_in_centimeters >= (1 << distance_width) ||
        near_threshold_in_centimeters >= (1 << distance_width)) begin : g_bad_width
        $error("distance_width too narrow for range or near threshold");
    end

    typedef enum logic [1:0] {st_trig, st_wait, st_meas, st_gap} state_t;

    state_t                    state, state_next;
    logic [cnt_w-1:0]          slot_cnt;
    logic [ch_width-1:0]       ch;
    logic [n_channels-1:0]     sync1, sync2, ch_onehot;
    logic                      echo_prev, echo_sel, rise, fall;
    logic [psc_w-1:0]          psc;
    logic [distance_width-1:0] cm, cm_next;
    logic                      meas_start, result_write, result_timeout;
    logic [distance_width-1:0] result_distance;

    assign echo_sel = sync2[ch];
    assign rise     = echo_sel & ~echo_prev;
    assign fall     = ~echo_sel & echo_prev;
    // The counter saturates at max so a stuck-high echo can never wrap it.
    assign cm_next  = (psc == psc_last && cm != max_cm) ? cm + 1'b1 : cm;

    // Decode the active channel into a trigger mask.
    always_comb begin
        ch_onehot     = '0;
        ch_onehot[ch] = 1'b1;
    end

    // Two-flop synchronizer on every echo pin plus an edge-detect copy of the selected channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            echo_prev <= 1'b0;
        end else begin
            sync1     <= echo;
            sync2     <= sync1;
            echo_prev <= echo_sel;
        end
    end

    // Slot timer and round-robin channel pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            ch       <= '0;
        end else if (slot_cnt == slot_last) begin
            slot_cnt <= '0;
            ch       <= (ch == ch_last) ? '0 : ch + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= st_trig;
        else       state <= state_next;
    end

    // Next state and result selection; the slot boundary always restarts in TRIG.
    always_comb begin
        state_next      = state;
        meas_start      = 1'b0;
        result_write    = 1'b0;
        result_timeout  = 1'b0;
        result_distance = '0;
        case (state)
            st_trig: if (slot_cnt == trig_last) state_next = st_wait;
            st_wait: begin
                if (rise) begin
                    meas_start = 1'b1;
                    state_next = st_meas;
                end else if (slot_cnt == wait_last) begin
                    result_write    = 1'b1;
                    result_timeout  = 1'b1;
                    result_distance = max_cm;
                    state_next      = st_gap;
                end
            end
            st_meas: begin
                // A falling edge in the saturation cycle still counts as a real echo.
                if (fall) begin
                    result_write    = 1'b1;
                    result_distance = cm_next;
                    state_next      = st_gap;
                end else if (cm_next == max_cm) begin
                    result_write    = 1'b1;
                    result_timeout  = 1'b1;
                    result_distance = max_cm;
                    state_next      = st_gap;
                end
            end
            default: state_next = st_gap;
        endcase
        if (slot_cnt == slot_last) state_next = st_trig;
    end

    // Prescaler and centimetre counter, cleared on the rising edge of the echo.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc <= '0;
            cm  <= '0;
        end else if (meas_start) begin
            psc <= '0;
            cm  <= '0;
        end else if (state == st_meas) begin
            psc <= (psc == psc_last) ? '0 : psc + 1'b1;
            cm  <= cm_next;
        end
    end

    // Registered trigger so it stays low during reset and rises on the first clock after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) trig <= '0;
        else       trig <= (state == st_trig && slot_cnt < trig_end) ? ch_onehot : '0;
    end

    // Result registers and measurement strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            distance       <= '0;
            valid          <= '0;
            timeout        <= '0;
            strobe         <= 1'b0;
            strobe_channel <= '0;
        end else begin
            strobe <= result_write;
            if (result_write) begin
                distance[ch*distance_width +: distance_width] <= result_distance;
                timeout[ch]    <= result_timeout;
                valid[ch]      <= 1'b1;
                strobe_channel <= ch;
            end
        end
    end

`ifdef ULTRASONIC_NEAR_DETECT_EN
    localparam logic [distance_width-1:0] near_cm = distance_width'(near_threshold_in_centimeters);

    // Near flag derived from the stored result, one cycle behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            near <= '0;
        end else begin
            for (int k = 0; k < n_channels; k++) begin
                near[k] <= valid[k] & ~timeout[k] &
                           (distance[k*distance_width +: distance_width] < near_cm);
            end
        end
    end
`else
    assign near = '0;
`endif

endmodule

// File: tb/tb_ultrasonic_multi_sensor.sv
// tb/tb_ultrasonic_multi_sensor.sv - randomized self-checking bench for ultrasonic_multi_sensor
`timescale 1ns/1ps
module tb_ultrasonic_multi_sensor;

    localparam int clk_frequency  = 1000000;
    localparam int n_channels     = 4;
    localparam int distance_width = 9;
    localparam int max_range      = 40;
    localparam int slot_ms        = 5;
    localparam int trig_us        = 10;
    localparam int near_thr       = 30;
    localparam int slot_time      = slot_ms * (clk_frequency / 1000);
    localparam int trig_time      = trig_us * (clk_frequency / 1000000);
    localparam int cycles_per_cm  = clk_frequency * 2 / 343 / 100;
    localparam int timeout_time   = max_range * cycles_per_cm;

    logic                                 clk = 1'b0;
    logic                                 reset = 1'b1;
    logic [n_channels-1:0]                echo = '0;
    logic [n_channels-1:0]                trig, valid, timeout, near;
    logic [n_channels*distance_width-1:0] distance;
    logic                                 strobe;
    logic [1:0]                           strobe_channel;

    ultrasonic_multi_sensor #(
        .clk_frequency(clk_frequency), .n_channels(n_channels), .distance_width(distance_width),
        .max_range_in_centimeters(max_range), .slot_in_milliseconds(slot_ms),
        .trig_time_in_microseconds(trig_us), .near_threshold_in_centimeters(near_thr)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig), .echo(echo), .distance(distance),
        .valid(valid), .timeout(timeout), .near(near), .strobe(strobe),
        .strobe_channel(strobe_channel)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int cycle = 0, strobe_count = 0, last_strobe_cycle = 0, last_strobe_ch = 0, overlap_count = 0;
    int prev_rise = -1, prev_rise_ch = 0;
    int exp_dist[n_channels], exp_to[n_channels], exp_valid[n_channels];

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            strobe_count++;
            last_strobe_cycle = cycle;
            last_strobe_ch    = int'(strobe_channel);
        end
        if ($countones(trig) > 1) overlap_count++;
    end

    function automatic logic [n_channels*distance_width-1:0] exp_bus();
        logic [n_channels*distance_width-1:0] b;
        for (int i = 0; i < n_channels; i++) b[i*distance_width +: distance_width] = exp_dist[i][distance_width-1:0];
        return b;
    endfunction

    function automatic logic [n_channels-1:0] exp_bits(input bit sel_to);
        logic [n_channels-1:0] v;
        for (int i = 0; i < n_channels; i++) v[i] = sel_to ? (exp_to[i] != 0) : (exp_valid[i] != 0);
        return v;
    endfunction

    function automatic logic [n_channels-1:0] exp_near();
        logic [n_channels-1:0] v;
        v = '0;
`ifdef ULTRASONIC_NEAR_DETECT_EN
        for (int i = 0; i < n_channels; i++)
            v[i] = (exp_valid[i] != 0) && (exp_to[i] == 0) && (exp_dist[i] < near_thr);
`endif
        return v;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < n_channels; i++) begin exp_dist[i] = 0; exp_to[i] = 0; exp_valid[i] = 0; end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({trig, distance, valid, timeout, near, strobe, strobe_channel} !== '0) begin
            $display("FAIL reset_outputs: got trig=%b dist=%h valid=%b to=%b near=%b strobe=%b sch=%0d, want all zero",
                     trig, distance, valid, timeout, near, strobe, strobe_channel);
        end else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (trig !== 4'b0001) $display("FAIL first_trig: got %b want 0001", trig);
        else passed++;
        prev_rise = -1;
        @(negedge clk);
    endtask

    // One measurement slot: width 0 means no echo; xtalk pulses echo[3] instead of the selected channel.
    task automatic run_slot(input int k, input int width, input bit xtalk);
        int n, t_trig_end, t_start, t_end, c0, dly, exp_cycle, diff;
        n = 0;
        while (trig[k] !== 1'b1 && n < slot_time * n_channels + 100) begin @(negedge clk); n++; end
        total++;
        if (trig[k] !== 1'b1) $display("FAIL trig_start ch%0d: trig=%b never rose", k, trig);
        else passed++;
        if (prev_rise >= 0 && prev_rise_ch == (k + n_channels - 1) % n_channels) begin
            total++;
            if (cycle - prev_rise !== slot_time)
                $display("FAIL slot_spacing ch%0d: got %0d cycles want %0d", k, cycle - prev_rise, slot_time);
            else passed++;
        end
        prev_rise = cycle; prev_rise_ch = k;
        n = 0;
        while (trig[k] === 1'b1 && n < 100) begin @(negedge clk); n++; end
        total++;
        if (n !== trig_time) $display("FAIL trig_width ch%0d: got %0d want %0d", k, n, trig_time);
        else passed++;
        t_trig_end = cycle;
        c0 = strobe_count;
        dly = $urandom_range(5, 400);
        repeat (dly) @(negedge clk);
        t_start = cycle;
        if (width > 0) begin
            if (xtalk) echo[3] = 1'b1; else echo[k] = 1'b1;
            repeat (width) @(negedge clk);
            echo = '0;
        end
        t_end = cycle;
        n = 0;
        while (strobe_count == c0 && n < slot_time) begin @(negedge clk); n++; end
        exp_valid[k] = 1;
        if (width == 0 || xtalk) begin
            exp_dist[k] = max_range; exp_to[k] = 1; exp_cycle = t_trig_end + timeout_time;
        end else if (width <= max_range * cycles_per_cm) begin
            exp_dist[k] = width / cycles_per_cm; exp_to[k] = 0; exp_cycle = t_end + 3;
        end else begin
            exp_dist[k] = max_range; exp_to[k] = 1; exp_cycle = t_start + timeout_time + 3;
        end
        diff = last_strobe_cycle - exp_cycle;
        total++;
        if (strobe_count == c0 || diff < -3 || diff > 3)
            $display("FAIL strobe_time ch%0d: strobes=%0d at cycle %0d want near %0d", k, strobe_count - c0, last_strobe_cycle, exp_cycle);
        else passed++;
        total++;
        if (last_strobe_ch !== k) $display("FAIL strobe_channel: got %0d want %0d", last_strobe_ch, k);
        else passed++;
        total++;
        if (distance !== exp_bus()) $display("FAIL distance ch%0d w=%0d: got %h want %h", k, width, distance, exp_bus());
        else passed++;
        total++;
        if (timeout !== exp_bits(1'b1)) $display("FAIL timeout ch%0d: got %b want %b", k, timeout, exp_bits(1'b1));
        else passed++;
        total++;
        if (valid !== exp_bits(1'b0)) $display("FAIL valid ch%0d: got %b want %b", k, valid, exp_bits(1'b0));
        else passed++;
        @(negedge clk);
        total++;
        if (near !== exp_near()) $display("FAIL near ch%0d: got %b want %b", k, near, exp_near());
        else passed++;
        n = 0;
        while (trig === '0 && n < slot_time + 10) begin @(negedge clk); n++; end
        total++;
        if (strobe_count - c0 !== 1) $display("FAIL strobe_count ch%0d: got %0d want 1", k, strobe_count - c0);
        else passed++;
    endtask

    task automatic test_reset_mid_meas();
        int n;
        n = 0;
        while (trig[2] !== 1'b1 && n < slot_time * n_channels) begin @(negedge clk); n++; end
        while (trig[2] === 1'b1 && n < slot_time * n_channels) begin @(negedge clk); n++; end
        repeat (50) @(negedge clk);
        echo[2] = 1'b1;
        repeat (300) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({trig, distance, valid, timeout, near, strobe, strobe_channel} !== '0)
            $display("FAIL reset_mid_meas: got trig=%b dist=%h valid=%b to=%b near=%b, want all zero",
                     trig, distance, valid, timeout, near);
        else passed++;
        echo = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (trig !== 4'b0001) $display("FAIL trig_restart: got %b want 0001", trig);
        else passed++;
    endtask

    initial begin
        test_reset();
        run_slot(0, 580, 1'b0);
        run_slot(1, timeout_time + $urandom_range(20, 1200), 1'b0);
        run_slot(2, 0, 1'b0);
        run_slot(3, $urandom_range(cycles_per_cm, timeout_time + 150), 1'b0);
        run_slot(0, 300, 1'b1);
        run_slot(1, 1160, 1'b0);
        run_slot(2, timeout_time, 1'b0);
        run_slot(3, $urandom_range(cycles_per_cm, timeout_time - 1), 1'b0);
        run_slot(0, 1682, 1'b0);
        run_slot(1, 1740, 1'b0);
        test_reset_mid_meas();
        total++;
        if (overlap_count !== 0) $display("FAIL trig_overlap: got %0d overlapping cycles want 0", overlap_count);
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
